// File: rtl/addsub_pipe.sv
// Multi-lane signed add/subtract pipeline with optional saturation, per-lane
// overflow flags, sticky overflow status and valid/ready backpressure.
module addsub_pipe #(
  parameter int WIDTH    = 32,
  parameter int LANES    = 4,
  parameter int STAGES   = 2,
  parameter int SATURATE = 1
) (
  input  logic                   clk,
  input  logic                   reset_l,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] f,
  output logic [LANES-1:0]       ovf,
  output logic                   ovf_sticky,
  input  logic                   clr_sticky
);

  logic                   en;
  logic [LANES*WIDTH-1:0] res;
  logic [LANES-1:0]       res_ovf;

  logic [STAGES-1:0]      vld;
  logic [LANES*WIDTH-1:0] dat [STAGES];
  logic [LANES-1:0]       ovr [STAGES];

  // The whole pipe stalls as one unit; bubbles are kept, not collapsed.
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH:0] ea;
    logic [WIDTH:0] eb;
    logic [WIDTH:0] s;

    assign ea         = {a[i*WIDTH+WIDTH-1], a[i*WIDTH +: WIDTH]};
    assign eb         = {b[i*WIDTH+WIDTH-1], b[i*WIDTH +: WIDTH]};
    assign s          = op ? (ea - eb) : (ea + eb);
    assign res_ovf[i] = s[WIDTH] ^ s[WIDTH-1];

    if (SATURATE != 0) begin : g_sat
      // Sign of the extended sum tells which rail was crossed.
      assign res[i*WIDTH +: WIDTH] = !res_ovf[i] ? s[WIDTH-1:0] :
                                     s[WIDTH]    ? {1'b1, {(WIDTH-1){1'b0}}} :
                                                   {1'b0, {(WIDTH-1){1'b1}}};
    end else begin : g_wrap
      assign res[i*WIDTH +: WIDTH] = s[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      vld <= '0;
      for (int k = 0; k < STAGES; k++) begin
        dat[k] <= '0;
        ovr[k] <= '0;
      end
    end else if (en) begin
      vld[0] <= in_valid;
      dat[0] <= res;
      ovr[0] <= res_ovf;
      for (int k = 1; k < STAGES; k++) begin
        vld[k] <= vld[k-1];
        dat[k] <= dat[k-1];
        ovr[k] <= ovr[k-1];
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign f         = dat[STAGES-1];
  assign ovf       = ovr[STAGES-1];

  // Set on a delivered overflow takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      ovf_sticky <= 1'b0;
    end else if (out_valid && out_ready && (|ovf)) begin
      ovf_sticky <= 1'b1;
    end else if (clr_sticky) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe: a saturating and a wrapping instance share
// one stimulus stream, WIDTH=8, LANES=2, STAGES=2.
module tb_addsub_pipe;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        in_valid;
  logic        op;
  logic        out_ready;
  logic        clr_sticky;
  logic [15:0] a;
  logic [15:0] b;

  logic        s_in_ready, s_out_valid, s_sticky;
  logic [15:0] s_f;
  logic [1:0]  s_ovf;
  logic        w_in_ready, w_out_valid, w_sticky;
  logic [15:0] w_f;
  logic [1:0]  w_ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(8), .LANES(2), .STAGES(2), .SATURATE(1)) u_sat (
    .clk(clk), .reset_l(reset_l), .in_valid(in_valid), .in_ready(s_in_ready),
    .op(op), .a(a), .b(b), .out_valid(s_out_valid), .out_ready(out_ready),
    .f(s_f), .ovf(s_ovf), .ovf_sticky(s_sticky), .clr_sticky(clr_sticky)
  );

  addsub_pipe #(.WIDTH(8), .LANES(2), .STAGES(2), .SATURATE(0)) u_wrap (
    .clk(clk), .reset_l(reset_l), .in_valid(in_valid), .in_ready(w_in_ready),
    .op(op), .a(a), .b(b), .out_valid(w_out_valid), .out_ready(out_ready),
    .f(w_f), .ovf(w_ovf), .ovf_sticky(w_sticky), .clr_sticky(clr_sticky)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_l = 1'b0; in_valid = 1'b0; op = 1'b0; out_ready = 1'b1;
    clr_sticky = 1'b0; a = '0; b = '0;
    #1;
    checks++;
    if ({s_out_valid, w_out_valid, s_sticky, w_sticky} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {s_out_valid, w_out_valid, s_sticky, w_sticky});
    end
    checks++;
    if ({s_f, w_f, s_ovf, w_ovf} !== 36'h0) begin
      errors++; $display("FAIL reset_data got %h want 0", {s_f, w_f, s_ovf, w_ovf});
    end
    checks++;
    if ({s_in_ready, w_in_ready} !== 2'b11) begin
      errors++; $display("FAIL reset_in_ready got %b want 11", {s_in_ready, w_in_ready});
    end
    tick(); tick();
    reset_l = 1'b1;
    tick();
  endtask

  task automatic test_add_ovf();
    in_valid = 1'b1; op = 1'b0; a = 16'h107F; b = 16'h0501; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if ({s_out_valid, w_out_valid} !== 2'b11) begin
      errors++; $display("FAIL add_valid got %b want 11", {s_out_valid, w_out_valid});
    end
    checks++;
    if (s_f !== 16'h157F) begin
      errors++; $display("FAIL add_sat_f got %h want 157f", s_f);
    end
    checks++;
    if (w_f !== 16'h1580) begin
      errors++; $display("FAIL add_wrap_f got %h want 1580", w_f);
    end
    checks++;
    if ({s_ovf, w_ovf} !== 4'b0101) begin
      errors++; $display("FAIL add_ovf got %b want 0101", {s_ovf, w_ovf});
    end
    tick();
  endtask

  task automatic test_sub_ovf();
    in_valid = 1'b1; op = 1'b1; a = 16'h0080; b = 16'h8001;
    tick();
    a = 16'h0530; b = 16'h0710;
    tick();
    in_valid = 1'b0;
    checks++;
    if (s_f !== 16'h7F80 || w_f !== 16'h807F) begin
      errors++; $display("FAIL sub_f got sat=%h wrap=%h want 7f80/807f", s_f, w_f);
    end
    checks++;
    if ({s_ovf, w_ovf} !== 4'b1111) begin
      errors++; $display("FAIL sub_ovf got %b want 1111", {s_ovf, w_ovf});
    end
    tick();
    checks++;
    if (s_f !== 16'hFE20 || w_f !== 16'hFE20 || {s_ovf, w_ovf} !== 4'b0000 || s_out_valid !== 1'b1) begin
      errors++; $display("FAIL sub_plain got sat=%h wrap=%h ovf=%b v=%b want fe20 ovf 0000 v 1",
                         s_f, w_f, {s_ovf, w_ovf}, s_out_valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp [4];
    exp[0] = 16'h0111; exp[1] = 16'h0212; exp[2] = 16'h0313; exp[3] = 16'h0414;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 4);
      op = 1'b0;
      a = {8'(c), 8'(c + 1)};
      b = 16'h0110;
      #1;
      checks++;
      if (s_in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_in_ready cycle %0d got %b want 1", c, s_in_ready);
      end
      checks++;
      if (s_out_valid !== ((c >= 2) && (c <= 5))) begin
        errors++; $display("FAIL b2b_valid cycle %0d got %b want %b", c, s_out_valid, (c >= 2) && (c <= 5));
      end
      if (c >= 2 && c <= 5) begin
        checks++;
        if (s_f !== exp[c-2] || w_f !== exp[c-2]) begin
          errors++; $display("FAIL b2b_f cycle %0d got %h/%h want %h", c, s_f, w_f, exp[c-2]);
        end
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [15:0] va [5];
    logic [15:0] ex [5];
    logic [15:0] held;
    int idx = 0;
    int oidx = 0;
    logic acc;
    va[0] = 16'h4000; va[1] = 16'h4103; va[2] = 16'h4206; va[3] = 16'h4309; va[4] = 16'h440C;
    ex[0] = 16'h4201; ex[1] = 16'h3F02; ex[2] = 16'h4407; ex[3] = 16'h4108; ex[4] = 16'h460D;
    held = '0;
    for (int c = 0; c < 30 && oidx < 5; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (idx < 5);
      op        = idx[0];
      b         = 16'h0201;
      if (idx < 5) a = va[idx];
      #1;
      if (c == 3) held = s_f;
      if (c >= 3 && c <= 5) begin
        checks++;
        if (s_out_valid !== 1'b1 || s_in_ready !== 1'b0 || w_in_ready !== 1'b0) begin
          errors++; $display("FAIL bp_stall cycle %0d got v=%b rdy=%b/%b want v=1 rdy=0",
                             c, s_out_valid, s_in_ready, w_in_ready);
        end
        if (c > 3) begin
          checks++;
          if (s_f !== held || w_f !== held) begin
            errors++; $display("FAIL bp_hold cycle %0d got %h/%h want %h", c, s_f, w_f, held);
          end
        end
      end
      if (s_out_valid && out_ready) begin
        checks++;
        if (s_f !== ex[oidx] || w_f !== ex[oidx] || s_ovf !== 2'b00) begin
          errors++; $display("FAIL bp_order item %0d got %h/%h want %h", oidx, s_f, w_f, ex[oidx]);
        end
        oidx++;
      end
      acc = in_valid && s_in_ready;
      tick();
      if (acc) idx++;
    end
    checks++;
    if (oidx != 5 || idx != 5) begin
      errors++; $display("FAIL bp_count got out=%0d in=%0d want 5/5", oidx, idx);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
  endtask

  task automatic test_sticky();
    checks++;
    if ({s_sticky, w_sticky} !== 2'b11) begin
      errors++; $display("FAIL sticky_initial got %b want 11", {s_sticky, w_sticky});
    end
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    checks++;
    if ({s_sticky, w_sticky} !== 2'b00) begin
      errors++; $display("FAIL sticky_clear got %b want 00", {s_sticky, w_sticky});
    end
    // Overflow result held at the output must not set the flag until it transfers.
    out_ready = 1'b0; in_valid = 1'b1; op = 1'b0; a = 16'h107F; b = 16'h0501;
    tick();
    in_valid = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (s_sticky !== 1'b0 || s_out_valid !== 1'b1) begin
        errors++; $display("FAIL sticky_held cycle %0d got s=%b v=%b want s=0 v=1", c, s_sticky, s_out_valid);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({s_sticky, w_sticky} !== 2'b11) begin
      errors++; $display("FAIL sticky_set got %b want 11", {s_sticky, w_sticky});
    end
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    checks++;
    if ({s_sticky, w_sticky} !== 2'b00) begin
      errors++; $display("FAIL sticky_clear2 got %b want 00", {s_sticky, w_sticky});
    end
    // Clean result delivered: flag stays clear.
    in_valid = 1'b1; a = 16'h0102; b = 16'h0101;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    checks++;
    if ({s_sticky, w_sticky} !== 2'b00) begin
      errors++; $display("FAIL sticky_clean got %b want 00", {s_sticky, w_sticky});
    end
    // Clear coinciding with an overflow transfer: set wins.
    in_valid = 1'b1; op = 1'b1; a = 16'h0080; b = 16'h8001;
    tick();
    in_valid = 1'b0;
    tick();
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    checks++;
    if ({s_sticky, w_sticky} !== 2'b11) begin
      errors++; $display("FAIL sticky_set_wins got %b want 11", {s_sticky, w_sticky});
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1; in_valid = 1'b1; op = 1'b0; a = 16'h0102; b = 16'h0101;
    tick();
    a = 16'h0304;
    tick();
    in_valid = 1'b0;
    #2;
    reset_l = 1'b0;
    #1;
    checks++;
    if ({s_out_valid, w_out_valid, s_sticky, w_sticky} !== 4'b0000 || s_f !== 16'h0 || w_f !== 16'h0) begin
      errors++; $display("FAIL mid_reset got v=%b st=%b f=%h/%h want 0",
                         {s_out_valid, w_out_valid}, {s_sticky, w_sticky}, s_f, w_f);
    end
    tick();
    reset_l = 1'b1;
    tick();
    in_valid = 1'b1; op = 1'b1; a = 16'h2030; b = 16'h0102;
    tick();
    in_valid = 1'b0;
    checks++;
    if (s_out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_early got %b want 0", s_out_valid);
    end
    tick();
    checks++;
    if (s_out_valid !== 1'b1 || s_f !== 16'h1F2E || w_f !== 16'h1F2E) begin
      errors++; $display("FAIL post_reset_first got v=%b f=%h/%h want 1 1f2e", s_out_valid, s_f, w_f);
    end
    tick();
    checks++;
    if ({s_out_valid, w_out_valid} !== 2'b00) begin
      errors++; $display("FAIL post_reset_stale got %b want 00", {s_out_valid, w_out_valid});
    end
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_sub_ovf();
    test_back_to_back();
    test_backpressure();
    test_sticky();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Pipelined, multi-lane, signed fixed-point adder/subtractor. Successor to the single-lane fixed-latency subtractor.
- Adds the following over that block: per-transaction add/sub mode, optional saturation, per-lane overflow flags, a sticky overflow status and valid/ready flow control with backpressure.
- Sits in the matrix datapath as the element-wise add/sub engine feeding accumulators and vector units.

Parameters:
- WIDTH, 32: lane width in bits; signed two's complement fixed point. The binary point is irrelevant to add/sub.
- LANES, 4: number of independent lanes processed per transaction.
- STAGES, 2: pipeline depth in register stages. Must be ≥1.
- SATURATE, 1: 1 = clamp on overflow; 0 = wrap modulo 2^WIDTH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_l  in  1  asynchronous, active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block accepts input this cycle.
- op  in  1  0 = a+b, 1 = a-b; applies to all lanes of the transaction.
- a  in  LANES*WIDTH  operand A. Lane i occupies bits [i*WIDTH +: WIDTH].
- b  in  LANES*WIDTH  operand B, same packing as a.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- f  out  LANES*WIDTH  result, same packing as a.
- ovf  out  LANES  per-lane overflow flag, aligned with f.
- ovf_sticky  out  1  set when any delivered result had overflow.
- clr_sticky  in  1  synchronous clear of ovf_sticky.

Behaviour:
- Reset (reset_l low, asynchronous):
  - all stage valid bits, out_valid, f, ovf and ovf_sticky go to 0 immediately.
  - in_ready is 1 once out_valid is 0.
  - In-flight transactions are discarded.
  - Release is synchronous to clk.
- Pipeline advance:
  - en = out_ready | ~out_valid; in_ready = en.
  - When en=1 every stage shifts one step. Stage 0 loads {in_valid, op result}.
  - When en=0 all stages hold, including data.
  - Bubbles are not collapsed.
- Transfers:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - in_valid is ignored while in_ready=0; the upstream holds.
- Latency:
  - With no stall, a transaction accepted on edge N appears with out_valid=1 after edge N+STAGES-1, i.e. STAGES cycles after presentation.
  - Throughput is 1 transaction/cycle.
- Arithmetic, computed in stage 0 per lane:
  - Both operands are sign-extended to WIDTH+1 bits.
  - s = a±b (WIDTH+1 bits).
  - Overflow: ovf_i = s[WIDTH] ^ s[WIDTH-1].
  - If SATURATE=1 and ovf_i=1: f_i = s[WIDTH] ? {1,0…0} (most negative) : {0,1…1} (most positive).
  - Otherwise f_i = s[WIDTH-1:0] (wrap).
  - Stages 1..STAGES-1 are pure delay with the same enable.
- Output holding: f and ovf are stable while out_valid=1 and out_ready=0.
- Data values when invalid: when out_valid=0, f and ovf carry whatever was last shifted in. Consumers must not sample them.
- Sticky overflow: in any cycle with an output transfer and |ovf, ovf_sticky ← 1.
  - Else if clr_sticky, ovf_sticky ← 0.
  - If set and clear occur together, set wins.
- Lanes are fully independent; one lane's overflow does not affect the others.
- Edge cases: a-b with b = most negative overflows whenever a ≥ 0. Saturation yields the most positive value.

Test Plan (WIDTH=8, LANES=2, STAGES=2 unless stated):
- Add with overflow, SATURATE=1: op=0, lane0 0x7F+0x01, lane1 0x10+0x05 -> f lane0=0x7F, lane1=0x15, ovf=2'b01. With SATURATE=0, lane0 -> 0x80 and ovf=2'b01.
- Subtract with overflow: op=1, lane0 0x80-0x01, lane1 0x00-0x80 -> SATURATE=1 gives 0x80/0x7F, ovf=2'b11. SATURATE=0 gives 0x7F/0x80.
- Latency and throughput: 4 back-to-back inputs with out_ready=1 (first presented cycle 0) -> out_valid high in cycles 2..5. Results arrive in order, with no gaps. in_ready stays 1.
- Backpressure: out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0 during the stall, f/ovf/out_valid held. After release, every input appears exactly once, in order.
- Reset mid-operation: assert reset_l low with 2 transactions in flight -> out_valid=0, f=0, ovf_sticky=0 immediately, before the next clk edge. After release, the first new input emerges with latency 2 and no stale data.
- Sticky: deliver one overflow result -> ovf_sticky=1. Pulse clr_sticky -> 0 next cycle. Pulse clr_sticky in the same cycle an overflow result transfers -> remains 1. An overflow result held with out_ready=0 does not set sticky until the cycle it transfers.
